fuzzy_result_collector: RTL and testbench

- Downstream of the 5-input min/max comparator tree.
- Tracks which comparator results are valid by shadowing its start-gated pipeline with a token shift register.
- Captures each valid 3-bit result and packs NUM_ELEM results into one frame word.
- Buffers frames in a small FIFO behind a valid/ready handshake that feeds the defuzzification stage.

---
 rtl/fuzzy_pkg.sv | 15 +
 rtl/fuzzy_frame_fifo.sv | 72 +++++++
 rtl/fuzzy_result_collector.sv | 164 ++++++++++++++++
 tb/tb_fuzzy_result_collector.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// Shared types for the fuzzy result collector slice: default result width,
// collector FSM state encoding and the default frame word type.
package fuzzy_pkg;

  localparam int unsigned DATA_W_DEF   = 3;
  localparam int unsigned NUM_ELEM_DEF = 4;

  typedef enum logic {
    IDLE,
    FILL
  } coll_state_e;

  typedef logic [NUM_ELEM_DEF*DATA_W_DEF-1:0] frame_t;

endpackage

// File: rtl/fuzzy_frame_fifo.sv
// Small frame FIFO: synchronous push/pop, full/empty flags, head shown
// combinationally on rdata. Storage resets to zero so rdata is never X.
module fuzzy_frame_fifo #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fuzzy_result_collector.sv
// Collects valid comparator-tree results into NUM_ELEM-element frames and
// buffers them in a FIFO behind a valid/ready handshake.
// A token shift register shadows the start-gated comparator pipeline so each
// valid result is captured exactly once.
// Optional feature macro: FUZZY_COLLECT_PEAK_EN adds io_out_peak, the maximum
// unsigned element of each frame, carried as a FIFO side field.
module fuzzy_result_collector
  import fuzzy_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned PIPE_LAT   = 3,
  parameter int unsigned NUM_ELEM   = NUM_ELEM_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_start,
  input  logic                       io_in_valid,
  input  logic [DATA_W-1:0]          io_result,
  input  logic                       io_flush,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  output logic [NUM_ELEM*DATA_W-1:0] io_out_bits,
  output logic                       io_overflow,
  output logic                       io_busy
`ifdef FUZZY_COLLECT_PEAK_EN
  ,
  output logic [DATA_W-1:0]          io_out_peak
`endif
);

  localparam int unsigned FW    = NUM_ELEM * DATA_W;
`ifdef FUZZY_COLLECT_PEAK_EN
  localparam int unsigned ENTRY_W = FW + DATA_W;
`else
  localparam int unsigned ENTRY_W = FW;
`endif
  localparam int unsigned CNT_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEM - 1);

  logic [PIPE_LAT-1:0] tok_q, tok_d;
  logic                adv_q, adv_d;
  coll_state_e         state_q, state_d;
  logic [CNT_W-1:0]    elem_cnt_q, elem_cnt_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic                overflow_q, overflow_d;
`ifdef FUZZY_COLLECT_PEAK_EN
  logic [DATA_W-1:0]   peak_q, peak_d;
`endif

  logic               capture;
  logic [CNT_W-1:0]   idx;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;

  assign capture = adv_q & tok_q[PIPE_LAT-1];
  assign pop     = ~fifo_empty & io_out_ready;

  // Token/advance tracking, frame assembly, push decision and overflow flag.
  // The completing element is merged into frame_d so the pushed word already
  // contains it in the same cycle.
  always_comb begin
    tok_d      = tok_q;
    adv_d      = io_start;
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    frame_d    = frame_q;
    push       = 1'b0;
`ifdef FUZZY_COLLECT_PEAK_EN
    peak_d     = peak_q;
`endif
    idx        = (state_q == IDLE) ? '0 : elem_cnt_q;

    if (io_flush) begin
      tok_d      = '0;
      adv_d      = 1'b0;
      elem_cnt_d = '0;
      state_d    = IDLE;
    end else begin
      if (io_start) begin
        tok_d = {tok_q[PIPE_LAT-2:0], io_in_valid};
      end
      if (capture) begin
        for (int unsigned i = 0; i < NUM_ELEM; i++) begin
          if (idx == CNT_W'(i)) begin
            frame_d[i*DATA_W +: DATA_W] = io_result;
          end
        end
`ifdef FUZZY_COLLECT_PEAK_EN
        if ((state_q == IDLE) || (io_result > peak_q)) begin
          peak_d = io_result;
        end
`endif
        if (idx == LAST_IDX) begin
          push       = 1'b1;
          elem_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          elem_cnt_d = idx + CNT_W'(1);
          state_d    = FILL;
        end
      end
    end

`ifdef FUZZY_COLLECT_PEAK_EN
    push_data  = {peak_d, frame_d};
`else
    push_data  = frame_d;
`endif
    overflow_d = overflow_q | (push & fifo_full & ~pop);
  end

  // Collector FSM and tracking registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tok_q      <= '0;
      adv_q      <= 1'b0;
      state_q    <= IDLE;
      elem_cnt_q <= '0;
      frame_q    <= '0;
      overflow_q <= 1'b0;
`ifdef FUZZY_COLLECT_PEAK_EN
      peak_q     <= '0;
`endif
    end else begin
      tok_q      <= tok_d;
      adv_q      <= adv_d;
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      frame_q    <= frame_d;
      overflow_q <= overflow_d;
`ifdef FUZZY_COLLECT_PEAK_EN
      peak_q     <= peak_d;
`endif
    end
  end

  fuzzy_frame_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign io_out_valid = ~fifo_empty;
  assign io_out_bits  = fifo_rdata[FW-1:0];
  assign io_overflow  = overflow_q;
  assign io_busy      = (elem_cnt_q != '0) | (|tok_q);
`ifdef FUZZY_COLLECT_PEAK_EN
  assign io_out_peak  = fifo_rdata[ENTRY_W-1:FW];
`endif

endmodule

// File: tb/tb_fuzzy_result_collector.sv
// Self-checking bench for fuzzy_result_collector: directed scenarios plus a
// randomized phase, all checked against a start-history reference model.
module tb_fuzzy_result_collector;
  import fuzzy_pkg::*;

  localparam int unsigned DW = 3;
  localparam int unsigned PL = 3;
  localparam int unsigned NE = 4;
  localparam int unsigned FD = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          io_start = 1'b0;
  logic          io_in_valid = 1'b0;
  logic [DW-1:0] io_result = '0;
  logic          io_flush = 1'b0;
  logic          io_out_ready = 1'b0;
  logic          io_out_valid;
  frame_t        io_out_bits;
  logic          io_overflow;
  logic          io_busy;
`ifdef FUZZY_COLLECT_PEAK_EN
  logic [DW-1:0] io_out_peak;
`endif

  fuzzy_result_collector #(
    .DATA_W     (DW),
    .PIPE_LAT   (PL),
    .NUM_ELEM   (NE),
    .FIFO_DEPTH (FD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_start     (io_start),
    .io_in_valid  (io_in_valid),
    .io_result    (io_result),
    .io_flush     (io_flush),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_overflow  (io_overflow),
    .io_busy      (io_busy)
`ifdef FUZZY_COLLECT_PEAK_EN
    ,
    .io_out_peak  (io_out_peak)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: history of in_valid bits of start cycles since the last
  // flush/reset, collected elements, expected FIFO contents, sticky overflow.
  bit            hist[$];
  bit            adv_m;
  logic [DW-1:0] elems[$];
  frame_t        fq[$];
  logic [DW-1:0] pq[$];
  bit            ovf_m;
  logic [DW-1:0] res_q[$];
  frame_t        got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A result is captured in the cycle after a start edge when the input set
  // accepted PL start edges ago was valid.
  function automatic bit cap_now();
    return adv_m && (hist.size() >= PL) && hist[hist.size() - PL];
  endfunction

  function automatic bit busy_m();
    bit b;
    b = (elems.size() != 0);
    foreach (hist[i]) if (hist[i]) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    hist.delete(); elems.delete(); fq.delete(); pq.delete();
    adv_m = 1'b0; ovf_m = 1'b0;
  endtask

  task automatic model_edge();
    bit     cap, pop;
    frame_t w;
    logic [DW-1:0] m;
    cap = cap_now();
    pop = (fq.size() > 0) && io_out_ready;
    if (pop) begin
      void'(fq.pop_front());
      void'(pq.pop_front());
    end
    if (io_flush) begin
      elems.delete(); hist.delete(); adv_m = 1'b0;
    end else begin
      if (cap) begin
        elems.push_back(io_result);
        if (elems.size() == NE) begin
          w = '0;
          m = elems[0];
          for (int i = 0; i < NE; i++) begin
            w[i*DW +: DW] = elems[i];
            if (elems[i] > m) m = elems[i];
          end
          if (fq.size() < FD) begin
            fq.push_back(w);
            pq.push_back(m);
          end else begin
            ovf_m = 1'b1;
          end
          elems.delete();
        end
      end
      if (io_start) begin
        hist.push_back(io_in_valid);
        while (hist.size() > PL) void'(hist.pop_front());
      end
      adv_m = io_start;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", io_out_valid, fq.size() > 0);
    if (fq.size() > 0) begin
      chk("out_bits", io_out_bits, fq[0]);
`ifdef FUZZY_COLLECT_PEAK_EN
      chk("out_peak", io_out_peak, pq[0]);
`endif
    end
    chk("overflow", io_overflow, ovf_m);
    chk("busy", io_busy, busy_m());
  endtask

  // One clock cycle: check at negedge, drive inputs, record pops, then edge.
  task automatic step(input bit s, input bit v, input bit f, input bit r);
    check_outputs();
    io_start = s; io_in_valid = v; io_flush = f; io_out_ready = r;
    if (!f && cap_now() && res_q.size() > 0) io_result = res_q.pop_front();
    else io_result = DW'($urandom);
    #1;
    if (io_out_valid && io_out_ready) got.push_back(io_out_bits);
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  bit s;
  bit fl;
  int nstart;
  bit gap_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk("rst_valid", io_out_valid, 0);
    chk("rst_bits", io_out_bits, 0);
    chk("rst_overflow", io_overflow, 0);
    chk("rst_busy", io_busy, 0);
`ifdef FUZZY_COLLECT_PEAK_EN
    chk("rst_peak", io_out_peak, 0);
`endif
    reset = 1'b1;

    // Streaming 5,1,7,2
    got.delete(); res_q = '{3'd5, 3'd1, 3'd7, 3'd2};
    for (int k = 0; k < 4; k++) step(1, 1, 0, 1);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 1);
    chk("stream_count", got.size(), 1);
    if (got.size() > 0) chk("stream_frame", got[0], 12'o2715);

    // Stalled pipeline with constant result 3
    got.delete(); res_q = '{3'd3, 3'd3, 3'd3, 3'd3}; nstart = 0;
    for (int k = 0; k < 24; k++) begin
      s = (k % 6 == 0) || (k % 6 == 3) || (k % 6 == 5);
      step(s, s && (nstart < 4), 0, 1);
      if (s) nstart++;
    end
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
    chk("stall_count", got.size(), 1);
    if (got.size() > 0) chk("stall_frame", got[0], 12'o3333);
    chk("stall_busy", io_busy, 0);

    // Invalid gaps
    got.delete(); res_q = '{3'd6, 3'd0, 3'd4, 3'd3};
    for (int k = 0; k < 6; k++) step(1, gap_pat[k], 0, 1);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 1);
    chk("gap_count", got.size(), 1);
    if (got.size() > 0) chk("gap_frame", got[0], 12'o3406);

    // Overflow: five frames into a four-deep FIFO
    got.delete();
    for (int k = 0; k < 20; k++) step(1, 1, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
    chk("ovf_set", io_overflow, 1);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1);
    chk("ovf_drain_count", got.size(), 4);
    chk("ovf_sticky", io_overflow, 1);
    chk("ovf_empty", io_out_valid, 0);

    // Flush with a coinciding capture; a buffered frame must survive
    got.delete();
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
    fl = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!fl) begin
        s = (elems.size() == 2) && cap_now();
        step(1, k < 4, s, 0);
        if (s) begin
          fl = 1'b1;
          chk("flush_busy", io_busy, 0);
          chk("flush_fifo_kept", io_out_valid, 1);
        end
      end
    end
    chk("flush_hit", fl, 1);
    res_q = '{3'd7, 3'd6, 3'd5, 3'd4};
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1);
    chk("flush_count", got.size(), 2);
    if (got.size() > 1) chk("flush_fresh_frame", got[1], 12'o4567);

    // Randomized phase
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1);

    // Asynchronous reset mid-frame with a frame buffered
    for (int k = 0; k < 8; k++) step(1, 1, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 1, 0, 0);
    io_start = 1'b0; io_in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", io_out_valid, 0);
    chk("arst_bits", io_out_bits, 0);
    chk("arst_overflow", io_overflow, 0);
    chk("arst_busy", io_busy, 0);
`ifdef FUZZY_COLLECT_PEAK_EN
    chk("arst_peak", io_out_peak, 0);
`endif
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    got.delete(); res_q = '{3'd1, 3'd2, 3'd3, 3'd4};
    for (int k = 0; k < 4; k++) step(1, 1, 0, 1);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 1);
    chk("arst_count", got.size(), 1);
    if (got.size() > 0) chk("arst_frame", got[0], 12'o4321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
